// File: rtl/midi_mmio_rx_pkg.sv
// Shared definitions for the MIDI memory-mapped receiver: register offsets,
// STATUS bit positions, receiver states and the STATUS word packer.
package midi_mmio_rx_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_POP    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FERR      = 2;
    localparam int ST_ENABLE    = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic enable,
                                                input logic ferr,
                                                input logic overrun,
                                                input logic full);
        logic [31:0] w;
        w = '0;
        w[ST_COUNT_LSB +: 8] = count;
        w[ST_ENABLE]         = enable;
        w[ST_FERR]           = ferr;
        w[ST_OVERRUN]        = overrun;
        w[ST_FULL]           = full;
        return w;
    endfunction

endpackage

// File: rtl/midi_mmio_rx_if.sv
// Processor data-memory bus as seen by a memory-mapped responder.
interface midi_mmio_rx_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic        hit;
    logic [31:0] rdata;

    modport master (output address_dmem, data, wren, input hit, rdata);
    modport slave  (input address_dmem, data, wren, output hit, rdata);
endinterface

// File: rtl/midi_mmio_rx_byte_fifo.sv
// Synchronous byte FIFO with push/pop/flush; pop on empty is ignored and a
// push on full only lands when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/midi_mmio_rx.sv
// MIDI 8N1 receiver feeding a byte FIFO, exposed as four memory-mapped words
// on the data-memory bus (DATA, STATUS, POP, CTRL).
module midi_mmio_rx
    import midi_mmio_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 31250,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    midi_mmio_rx_if.slave  bus,
    input  logic           midi_in,
    output logic           irq
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned TW  = $clog2(DIV);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] LAST    = TW'(DIV - 1);

    // Address decode; unsigned wrap keeps addresses below BASE_ADDR out of the window.
    logic [31:0] offset;
    logic [1:0]  reg_sel;
    logic        wr, pop_wr, ctrl_wr, flush, clr_err;

    assign offset  = bus.address_dmem - BASE_ADDR;
    assign bus.hit = (offset < 32'd4);
    assign reg_sel = offset[1:0];
    assign wr      = bus.wren && bus.hit;
    assign pop_wr  = wr && (reg_sel == OFF_POP);
    assign ctrl_wr = wr && (reg_sel == OFF_CTRL);
    assign flush   = ctrl_wr && bus.data[1];
    assign clr_err = ctrl_wr && bus.data[2];

    logic unused_data;
    assign unused_data = ^bus.data[31:3];

    logic [2:0] sync_q;
    logic       rx_bit, fall;

    assign rx_bit = sync_q[1];
    assign fall   = sync_q[2] && !sync_q[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 3'b111;
        else        sync_q <= {sync_q[1:0], midi_in};
    end

    rx_state_t     state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push, ferr_set;
    logic          enable_q, ferr_q, overrun_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (!enable_q) begin
            state_d = RX_IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    tick_d = '0;
                    if (fall) state_d = RX_START;
                end
                RX_START: begin
                    // Mid-start-bit check rejects short glitches.
                    if (tick_q == HALF_M1) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_bit ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_bit, shift_q[7:1]};
                        if (bit_q == 3'd7) state_d = RX_STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        state_d = RX_IDLE;
                        if (rx_bit) push     = 1'b1;
                        else        ferr_set = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    logic [7:0]    head;
    logic          full, empty;
    logic [CW-1:0] count;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop_wr),
        .flush (flush),
        .din   (shift_q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    logic [7:0] count8;
    if (CW >= 8) begin : g_cnt_trunc
        logic unused_cnt;
        assign count8     = count[7:0];
        assign unused_cnt = ^count;
    end else begin : g_cnt_ext
        assign count8 = {{(8 - CW){1'b0}}, count};
    end

    // A new error event wins over a same-cycle clear so it is never lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_q  <= 1'b1;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr) enable_q <= bus.data[0];
            if (ferr_set)     ferr_q <= 1'b1;
            else if (clr_err) ferr_q <= 1'b0;
            if (push && full && !pop_wr && !flush) overrun_q <= 1'b1;
            else if (clr_err)                      overrun_q <= 1'b0;
            irq <= !empty && enable_q;
        end
    end

    logic [31:0] rdata_c;

    always_comb begin
        rdata_c = '0;
        if (bus.hit) begin
            case (reg_sel)
                OFF_DATA:   rdata_c = {23'b0, !empty, (empty ? 8'h00 : head)};
                OFF_STATUS: rdata_c = status_word(count8, enable_q, ferr_q, overrun_q, full);
                OFF_CTRL:   rdata_c = {31'b0, enable_q};
                default:    rdata_c = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_midi_mmio_rx.sv
// Self-checking bench: serial frames driven on midi_in, register reads compared
// against a queue-based model of the byte buffer and error flags.
module tb_midi_mmio_rx;

    localparam int          DIV   = 16;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic midi_in = 1'b1;
    logic irq;

    midi_mmio_rx_if bus_if();

    midi_mmio_rx #(
        .CLK_HZ(16), .BAUD(1), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus_if), .midi_in(midi_in), .irq(irq)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes held, sticky flags, enable.
    logic [7:0] q[$];
    bit m_en = 1'b1, m_ferr = 1'b0, m_ovr = 1'b0;

    function automatic logic [31:0] exp_data();
        if (q.size() == 0) return 32'h0;
        return {23'b0, 1'b1, q[0]};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        w = '0;
        w[15:8] = 8'(q.size());
        w[3] = m_en;
        w[2] = m_ferr;
        w[1] = m_ovr;
        w[0] = (q.size() == DEPTH);
        return w;
    endfunction

    function automatic void m_frame(input logic [7:0] b, input bit stop_ok);
        if (!m_en) return;
        if (!stop_ok) m_ferr = 1'b1;
        else if (q.size() == DEPTH) m_ovr = 1'b1;
        else q.push_back(b);
    endfunction

    function automatic void m_pop();
        if (q.size() != 0) void'(q.pop_front());
    endfunction

    function automatic void m_ctrl(input logic [31:0] d);
        if (d[1]) q.delete();
        if (d[2]) begin m_ferr = 1'b0; m_ovr = 1'b0; end
        m_en = d[0];
    endfunction

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val, output logic h);
        @(negedge clock);
        bus_if.address_dmem = addr;
        bus_if.wren = 1'b0;
        #1;
        val = bus_if.rdata;
        h = bus_if.hit;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clock);
        bus_if.address_dmem = addr;
        bus_if.data = d;
        bus_if.wren = 1'b1;
        @(negedge clock);
        bus_if.wren = 1'b0;
        bus_if.address_dmem = 32'h0;
    endtask

    // Start bit, 8 data bits LSB first, stop bit, then one idle bit time.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(negedge clock);
        midi_in = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            repeat (DIV) @(negedge clock);
        end
        midi_in = stop_ok;
        repeat (DIV) @(negedge clock);
        midi_in = 1'b1;
        repeat (DIV) @(negedge clock);
    endtask

    // Ctrl/pop write whose active edge coincides with the stop-bit sample.
    task automatic write_at_push(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clock);
        repeat (153) @(negedge clock);
        bus_write(addr, d);
    endtask

    task automatic test_reset();
        logic [31:0] v; logic h;
        bus_if.address_dmem = 32'h0; bus_if.data = 32'h0; bus_if.wren = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (bus_if.hit !== 1'b0 || bus_if.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus hit=%b rdata=%h exp hit=0 rdata=0", bus_if.hit, bus_if.rdata); end
        reset = 1'b1;
        bus_read(BASE + 1, v, h);
        checks++; if (v !== 32'h0000_0008) begin errors++; $display("FAIL reset_status got=%h exp=00000008", v); end
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", v); end
        bus_read(BASE + 3, v, h);
        checks++; if (v !== 32'h1 || h !== 1'b1) begin errors++; $display("FAIL reset_ctrl got=%h hit=%b exp=1", v, h); end
    endtask

    task automatic test_single();
        logic [31:0] v; logic h;
        send_frame(8'h90, 1'b1); m_frame(8'h90, 1'b1);
        bus_read(BASE + 1, v, h);
        checks++; if (v !== 32'h0000_0108) begin errors++; $display("FAIL single_status got=%h exp=00000108", v); end
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0000_0190) begin errors++; $display("FAIL single_data got=%h exp=00000190", v); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got=%b exp=1", irq); end
        bus_write(BASE + 2, $urandom); m_pop();
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL single_pop_data got=%h exp=0", v); end
        bus_read(BASE + 1, v, h);
        checks++; if (v !== exp_status()) begin errors++; $display("FAIL single_pop_status got=%h exp=%h", v, exp_status()); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_overrun();
        logic [31:0] v; logic h;
        logic [7:0] bytes [5] = '{8'h90, 8'h3C, 8'h7F, 8'h40, 8'h11};
        foreach (bytes[i]) begin send_frame(bytes[i], 1'b1); m_frame(bytes[i], 1'b1); end
        bus_read(BASE + 1, v, h);
        checks++; if (v !== 32'h0000_040B || v !== exp_status()) begin
            errors++; $display("FAIL overrun_status got=%h exp=0000040b", v); end
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0000_0190) begin errors++; $display("FAIL overrun_data got=%h exp=00000190", v); end
        for (int i = 0; i < 3; i++) begin
            bus_write(BASE + 2, 32'h0); m_pop();
            bus_read(BASE + 0, v, h);
            checks++; if (v !== exp_data()) begin errors++; $display("FAIL overrun_pop%0d got=%h exp=%h", i, v, exp_data()); end
        end
        bus_write(BASE + 2, 32'h0); m_pop();
        bus_write(BASE + 3, 32'h5); m_ctrl(32'h5);
    endtask

    task automatic test_ferr();
        logic [31:0] v; logic h;
        send_frame(8'h55, 1'b0); m_frame(8'h55, 1'b0);
        bus_read(BASE + 1, v, h);
        checks++; if (v !== exp_status() || v[2] !== 1'b1) begin
            errors++; $display("FAIL ferr_status got=%h exp=%h", v, exp_status()); end
        bus_write(BASE + 3, 32'h5); m_ctrl(32'h5);
        bus_read(BASE + 1, v, h);
        checks++; if (v !== 32'h0000_0008) begin errors++; $display("FAIL ferr_clear got=%h exp=00000008", v); end
        bus_read(BASE + 3, v, h);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL ferr_ctrl got=%h exp=1", v); end
    endtask

    task automatic test_glitch();
        logic [31:0] v; logic h;
        @(negedge clock); midi_in = 1'b0;
        repeat (4) @(negedge clock); midi_in = 1'b1;
        repeat (3 * DIV) @(negedge clock);
        bus_read(BASE + 1, v, h);
        checks++; if (v !== exp_status()) begin errors++; $display("FAIL glitch_status got=%h exp=%h", v, exp_status()); end
        send_frame(8'h3A, 1'b1); m_frame(8'h3A, 1'b1);
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0000_013A) begin errors++; $display("FAIL glitch_next_data got=%h exp=0000013a", v); end
    endtask

    task automatic test_window();
        logic [31:0] v; logic h;
        logic [31:0] outside [2] = '{BASE - 1, BASE + 4};
        foreach (outside[i]) begin
            bus_read(outside[i], v, h);
            checks++; if (v !== 32'h0 || h !== 1'b0) begin
                errors++; $display("FAIL window_out%0d rdata=%h hit=%b exp 0/0", i, v, h); end
        end
        bus_read(BASE + 2, v, h);
        checks++; if (v !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL window_pop_read rdata=%h hit=%b exp 0/1", v, h); end
        bus_read(BASE + 0, v, h);
        checks++; if (v !== exp_data()) begin errors++; $display("FAIL window_no_side_effect got=%h exp=%h", v, exp_data()); end
    endtask

    task automatic test_pop_push_full();
        logic [31:0] v; logic h;
        logic [7:0] b;
        while (q.size() < DEPTH) begin
            b = 8'($urandom); send_frame(b, 1'b1); m_frame(b, 1'b1);
        end
        fork
            send_frame(8'h5A, 1'b1);
            write_at_push(BASE + 2, 32'h0);
        join
        m_pop(); m_frame(8'h5A, 1'b1);
        bus_read(BASE + 1, v, h);
        checks++; if (v !== exp_status() || v[1] !== 1'b0 || v[15:8] !== 8'd4) begin
            errors++; $display("FAIL pushpop_status got=%h exp=%h", v, exp_status()); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            bus_write(BASE + 2, 32'h0); m_pop();
        end
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0000_015A) begin errors++; $display("FAIL pushpop_tail got=%h exp=0000015a", v); end
    endtask

    task automatic test_flush_push();
        logic [31:0] v; logic h;
        fork
            send_frame(8'h22, 1'b1);
            write_at_push(BASE + 3, 32'h3);
        join
        q.delete();
        bus_read(BASE + 1, v, h);
        checks++; if (v !== 32'h0000_0008) begin errors++; $display("FAIL flush_push_status got=%h exp=00000008", v); end
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL flush_push_data got=%h exp=0", v); end
    endtask

    task automatic test_enable();
        logic [31:0] v; logic h;
        @(negedge clock); midi_in = 1'b0;
        repeat (3 * DIV) @(negedge clock);
        bus_write(BASE + 3, 32'h0); m_ctrl(32'h0);
        midi_in = 1'b1;
        bus_read(BASE + 3, v, h);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL enable_ctrl_off got=%h exp=0", v); end
        send_frame(8'h77, 1'b1); m_frame(8'h77, 1'b1);
        bus_write(BASE + 3, 32'h1); m_ctrl(32'h1);
        repeat (2 * DIV) @(negedge clock);
        bus_read(BASE + 1, v, h);
        checks++; if (v !== exp_status()) begin errors++; $display("FAIL enable_discard got=%h exp=%h", v, exp_status()); end
        send_frame(8'h45, 1'b1); m_frame(8'h45, 1'b1);
        bus_read(BASE + 0, v, h);
        checks++; if (v !== 32'h0000_0145) begin errors++; $display("FAIL enable_next_data got=%h exp=00000145", v); end
    endtask

    task automatic test_random();
        logic [31:0] v, d; logic h;
        logic [7:0] b;
        bit ok;
        int r;
        for (int it = 0; it < 24; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                b = 8'($urandom); ok = ($urandom_range(0, 7) != 0);
                send_frame(b, ok); m_frame(b, ok);
            end else if (r < 8) begin
                bus_write(BASE + 2, $urandom); m_pop();
            end else if (r == 8) begin
                d = $urandom; d[0] = ($urandom_range(0, 3) != 0);
                bus_write(BASE + 3, d); m_ctrl(d);
            end else begin
                bus_write(BASE + 32'($urandom_range(0, 1)), $urandom);
            end
            repeat (2) @(negedge clock);
            checks++; if (irq !== (m_en && q.size() != 0)) begin
                errors++; $display("FAIL rand%0d_irq got=%b exp=%b", it, irq, (m_en && q.size() != 0)); end
            bus_read(BASE + 0, v, h);
            checks++; if (v !== exp_data()) begin errors++; $display("FAIL rand%0d_data got=%h exp=%h", it, v, exp_data()); end
            bus_read(BASE + 1, v, h);
            checks++; if (v !== exp_status()) begin errors++; $display("FAIL rand%0d_status got=%h exp=%h", it, v, exp_status()); end
        end
        bus_write(BASE + 3, 32'h7); m_ctrl(32'h7);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v; logic h;
        send_frame(8'h12, 1'b1); send_frame(8'h34, 1'b1);
        @(negedge clock); midi_in = 1'b0;
        repeat (4 * DIV) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (irq !== 1'b0 || bus_if.rdata !== 32'h0 || bus_if.hit !== 1'b0) begin
            errors++; $display("FAIL resetmid_outputs irq=%b rdata=%h hit=%b exp all 0", irq, bus_if.rdata, bus_if.hit); end
        midi_in = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        q.delete(); m_en = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
        bus_read(BASE + 1, v, h);
        checks++; if (v !== 32'h0000_0008) begin errors++; $display("FAIL resetmid_status got=%h exp=00000008", v); end
        send_frame(8'h45, 1'b1); m_frame(8'h45, 1'b1);
        bus_read(BASE + 0, v, h);
        checks++; if (v !== exp_data()) begin errors++; $display("FAIL resetmid_rx got=%h exp=%h", v, exp_data()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_ferr();
        test_glitch();
        test_window();
        test_pop_push_full();
        test_flush_push();
        test_enable();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
